// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int DATA_W_DEF = 32;
    // Six bits covers 0..DATA_W-1 for the default 32-bit operand width.
    localparam int CNT_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MULT = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/muldiv_core.sv
// Single iteration step: one shift-add multiply bit or one restoring-divide bit.
// Latency: combinational.
// Backpressure: none; the sequencer decides when to register the results.
// Ports: acc (product accumulator / dividend-quotient shifter), rem, opnd
// (multiplicand or divisor magnitude), op -> acc_nxt, rem_nxt, q_bit.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  op_t               op,
    input  logic [2*DATA_W-1:0] acc,
    input  logic [DATA_W:0]   rem,
    input  logic [DATA_W-1:0] opnd,
    output logic [2*DATA_W-1:0] acc_nxt,
    output logic [DATA_W:0]   rem_nxt,
    output logic              q_bit
);

    logic [DATA_W:0]   sum;
    logic [DATA_W+1:0] rem_sh;
    logic [DATA_W+1:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (LSB) is set, then shift the whole accumulator right.
        sum     = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        acc_nxt = {sum, acc[DATA_W-1:1]};

        // Divide: bring the next dividend bit (MSB of the low half) into the
        // remainder and keep the difference only if it did not go negative.
        rem_sh  = {rem, acc[DATA_W-1]};
        diff    = rem_sh - {2'b00, opnd};
        q_bit   = ~diff[DATA_W+1];
        rem_nxt = (op == OP_DIV && q_bit) ? diff[DATA_W:0] : rem_sh[DATA_W:0];
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle signed mult/div engine: FSM, iteration counter, sign fix-up, HI/LO registers.
// Latency: 34 cycles start-to-Done (1 cycle for divide-by-zero).
// Backpressure: Busy high while running; starts during Busy are ignored, Flush aborts.
// Ports: Clock, Reset (async active-low), Start_Mult/Start_Div pulses, Op_A/Op_B,
// Flush -> Busy, Done, HILO_Write, Div_Zero, HI_Result, LO_Result.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start_Mult,
    input  logic              Start_Div,
    input  logic [DATA_W-1:0] Op_A,
    input  logic [DATA_W-1:0] Op_B,
    input  logic              Flush,
    output logic              Busy,
    output logic              Done,
    output logic              HILO_Write,
    output logic              Div_Zero,
    output logic [DATA_W-1:0] HI_Result,
    output logic [DATA_W-1:0] LO_Result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t              state, state_nxt;
    op_t                 op_q;
    logic [CNT_W-1:0]    cnt;
    logic                sign_a, sign_b, dz_q;
    logic [DATA_W-1:0]   opnd_q;
    logic [2*DATA_W-1:0] acc_q, acc_nxt;
    logic [DATA_W:0]     rem_q, rem_nxt;
    logic                q_bit;
    logic                go_mult, go_div;
    logic [DATA_W-1:0]   mag_a, mag_b;

    // Magnitudes as unsigned; the most negative value maps to itself.
    assign mag_a = Op_A[DATA_W-1] ? (~Op_A + 1'b1) : Op_A;
    assign mag_b = Op_B[DATA_W-1] ? (~Op_B + 1'b1) : Op_B;

    muldiv_core #(.DATA_W(DATA_W)) u_core (
        .op      (op_q),
        .acc     (acc_q),
        .rem     (rem_q),
        .opnd    (opnd_q),
        .acc_nxt (acc_nxt),
        .rem_nxt (rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        go_mult    = 1'b0;
        go_div     = 1'b0;
        Busy       = (state != ST_IDLE);
        // Flush suppresses completion outputs even on the DONE cycle itself.
        Done       = (state == ST_DONE) && !Flush;
        HILO_Write = (state == ST_DONE) && !Flush && !dz_q;
        Div_Zero   = (state == ST_DONE) && !Flush && dz_q;
        case (state)
            ST_IDLE: begin
                go_mult = Start_Mult && !Flush;
                go_div  = Start_Div && !Start_Mult && !Flush;
                if (go_mult)     state_nxt = ST_MULT;
                else if (go_div) state_nxt = (Op_B == '0) ? ST_DONE : ST_DIV;
            end
            ST_MULT, ST_DIV: begin
                if (Flush)                state_nxt = ST_IDLE;
                else if (cnt == CNT_LAST) state_nxt = ST_FIX;
            end
            ST_FIX:  state_nxt = Flush ? ST_IDLE : ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            op_q      <= OP_MULT;
            cnt       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            dz_q      <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            HI_Result <= '0;
            LO_Result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_mult || go_div) begin
                        op_q   <= go_mult ? OP_MULT : OP_DIV;
                        cnt    <= '0;
                        sign_a <= Op_A[DATA_W-1];
                        sign_b <= Op_B[DATA_W-1];
                        dz_q   <= go_div && (Op_B == '0);
                        rem_q  <= '0;
                        // Mult: multiplier |B| in the low half, multiplicand |A|.
                        // Div: dividend |A| in the low half, divisor |B|.
                        opnd_q <= go_mult ? mag_a : mag_b;
                        acc_q  <= {{DATA_W{1'b0}}, (go_mult ? mag_b : mag_a)};
                    end
                end
                ST_MULT, ST_DIV: begin
                    if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
                    if (op_q == OP_MULT) begin
                        acc_q <= acc_nxt;
                    end else begin
                        acc_q <= {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-2:0], q_bit};
                        rem_q <= rem_nxt;
                    end
                end
                ST_FIX: begin
                    if (op_q == OP_MULT) begin
                        {HI_Result, LO_Result} <= (sign_a ^ sign_b) ? (~acc_q + 1'b1) : acc_q;
                    end else begin
                        // Quotient truncates toward zero; remainder follows the dividend.
                        LO_Result <= (sign_a ^ sign_b) ? (~acc_q[DATA_W-1:0] + 1'b1)
                                                       : acc_q[DATA_W-1:0];
                        HI_Result <= sign_a ? (~rem_q[DATA_W-1:0] + 1'b1)
                                            : rem_q[DATA_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Start_Mult, Start_Div, Flush;
    logic [31:0] Op_A, Op_B;
    logic        Busy, Done, HILO_Write, Div_Zero;
    logic [31:0] HI_Result, LO_Result;

    muldiv_sequencer #(.DATA_W(32)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start_Mult (Start_Mult),
        .Start_Div  (Start_Div),
        .Op_A       (Op_A),
        .Op_B       (Op_B),
        .Flush      (Flush),
        .Busy       (Busy),
        .Done       (Done),
        .HILO_Write (HILO_Write),
        .Div_Zero   (Div_Zero),
        .HI_Result  (HI_Result),
        .LO_Result  (LO_Result)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic        is_div;
        logic        both;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Reference model using native signed arithmetic at 64 bits.
    function automatic exp_t model(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!is_div) begin
            p    = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else begin
            q    = sa / sb;
            r    = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Scoreboard: every write strobe must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (Reset === 1'b1 && HILO_Write === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_hilo_write: got write with hi=%h lo=%h, required none",
                         HI_Result, LO_Result);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("hi_result", {32'h0, HI_Result}, {32'h0, e.hi});
                check("lo_result", {32'h0, LO_Result}, {32'h0, e.lo});
                check("done_with_write", {63'h0, Done}, 64'h1);
            end
        end
    end

    // Issue one operation in cycle 0 and observe cycles 1..40.
    task automatic do_op(input logic is_div, input logic both, input logic [31:0] a,
                         input logic [31:0] b, output int done_cyc, output int busy_n);
        Op_A       = a;
        Op_B       = b;
        Start_Mult = !is_div || both;
        Start_Div  = is_div || both;
        step();
        Start_Mult = 1'b0;
        Start_Div  = 1'b0;
        done_cyc   = 0;
        busy_n     = 0;
        for (int c = 1; c <= 40; c++) begin
            if (Busy) busy_n++;
            if (Done && done_cyc == 0) done_cyc = c;
            step();
        end
    endtask

    vec_t vecs[8];
    int   done_cyc, busy_n, cyc, idle_bad;
    exp_t e;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[2] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3] = '{1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{1'b0, 1'b1, 32'h00000006, 32'h00000005, 32'h00000000, 32'h0000001E};
        vecs[6] = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7] = '{1'b1, 1'b0, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022};

        Reset = 1'b0; Start_Mult = 1'b0; Start_Div = 1'b0; Flush = 1'b0;
        Op_A = '0; Op_B = '0;
        step();
        step();
        check("rst_busy", {63'h0, Busy}, 64'h0);
        check("rst_done", {63'h0, Done}, 64'h0);
        check("rst_hilo_write", {63'h0, HILO_Write}, 64'h0);
        check("rst_div_zero", {63'h0, Div_Zero}, 64'h0);
        check("rst_hi_lo", {HI_Result, LO_Result}, 64'h0);
        Reset = 1'b1;
        step();

        // Table-driven operations; results are checked by the scoreboard.
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back('{vecs[i].hi, vecs[i].lo});
            do_op(vecs[i].is_div, vecs[i].both, vecs[i].a, vecs[i].b, done_cyc, busy_n);
            check($sformatf("vec%0d_done_cycle", i), 64'(done_cyc), 64'd34);
            check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd34);
        end

        // Divide by zero with HI/LO left at 0x11/0x22 by the last vector.
        Op_A = 32'd5; Op_B = 32'd0; Start_Div = 1'b1;
        step();
        Start_Div = 1'b0;
        check("dz_busy_c1", {63'h0, Busy}, 64'h1);
        check("dz_done_c1", {63'h0, Done}, 64'h1);
        check("dz_flag_c1", {63'h0, Div_Zero}, 64'h1);
        check("dz_write_c1", {63'h0, HILO_Write}, 64'h0);
        check("dz_hi_lo_held", {HI_Result, LO_Result}, {32'h11, 32'h22});
        step();
        check("dz_busy_c2", {63'h0, Busy}, 64'h0);
        check("dz_done_c2", {63'h0, Done}, 64'h0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 6; i++) begin
            logic        d;
            logic [31:0] a, b;
            d = 1'(i % 2);
            a = $urandom();
            b = $urandom();
            if (i == 4) b = {28'h0, 4'($urandom_range(1, 15))};
            if (b == 0) b = 32'h1;
            e = model(d, a, b);
            sb_q.push_back(e);
            do_op(d, 1'b0, a, b, done_cyc, busy_n);
            check($sformatf("rnd%0d_done_cycle", i), 64'(done_cyc), 64'd34);
        end

        // Mult flushed at cycle 10, with an ignored Start_Div at cycle 5.
        Op_A = 32'd3; Op_B = 32'd4; Start_Mult = 1'b1;
        step();
        Start_Mult = 1'b0;
        repeat (4) step();
        Op_A = 32'd100; Op_B = 32'd9; Start_Div = 1'b1;
        step();
        Start_Div = 1'b0;
        check("busy_after_ignored_div", {63'h0, Busy}, 64'h1);
        repeat (4) step();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        check("flush_busy_c11", {63'h0, Busy}, 64'h0);
        check("flush_hi_lo_held", {HI_Result, LO_Result}, {e.hi, e.lo});
        Op_A = 32'd100; Op_B = 32'd7; Start_Div = 1'b1;
        sb_q.push_back('{32'd2, 32'd14});
        step();
        Start_Div = 1'b0;
        cyc = 12;
        while (!Done && cyc < 60) begin
            step();
            cyc++;
        end
        check("post_flush_done_cycle", 64'(cyc), 64'd45);
        step();
        step();

        // Reset asserted in cycle 20 of a divide.
        Op_A = 32'd1000; Op_B = 32'd3; Start_Div = 1'b1;
        step();
        Start_Div = 1'b0;
        repeat (19) step();
        check("pre_reset_busy", {63'h0, Busy}, 64'h1);
        Reset = 1'b0;
        #1;
        check("midrst_busy", {63'h0, Busy}, 64'h0);
        check("midrst_strobes", {61'h0, Done, HILO_Write, Div_Zero}, 64'h0);
        check("midrst_hi_lo", {HI_Result, LO_Result}, 64'h0);
        step();
        Reset = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 40; c++) begin
            if (Busy || Done) idle_bad++;
            step();
        end
        check("post_reset_idle", 64'(idle_bad), 64'd0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
